// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the cell RAM controller and the RAM instantiation.
package mem_ctrl_pkg;

  localparam int unsigned MC_ADDR_W = 10;
  localparam int unsigned MC_DATA_W = 64;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_ALLOC = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

endpackage

// File: rtl/mem_ctrl.sv
// Initiator for the single-port cell RAM: request/response handshakes,
// read-latency absorption and the bump allocator for cons cells.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = MC_ADDR_W,
  parameter int unsigned DATA_W     = MC_DATA_W,
  parameter int unsigned ALLOC_BASE = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W:0]   free_ptr,
  output logic              mem_full
);

  localparam int unsigned    PTR_W   = ADDR_W + 1;
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(ALLOC_BASE);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  state_t              state, state_d;
  op_t                 op, op_d;
  logic                req_ready_d;
  logic                resp_valid_d;
  logic [DATA_W-1:0]   resp_data_d;
  logic [ADDR_W-1:0]   resp_addr_d;
  logic                resp_err_d;
  logic [ADDR_W-1:0]   ram_address_d;
  logic [DATA_W-1:0]   ram_data_d;
  logic                ram_wren_d;
  logic [PTR_W-1:0]    free_ptr_d;

  // Pointer saturates at 2**ADDR_W, so its MSB alone flags exhaustion.
  assign mem_full = free_ptr[ADDR_W];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      op          <= OP_READ;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_addr   <= '0;
      resp_err    <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      free_ptr    <= PTR_RST;
    end else begin
      state       <= state_d;
      op          <= op_d;
      req_ready   <= req_ready_d;
      resp_valid  <= resp_valid_d;
      resp_data   <= resp_data_d;
      resp_addr   <= resp_addr_d;
      resp_err    <= resp_err_d;
      ram_address <= ram_address_d;
      ram_data    <= ram_data_d;
      ram_wren    <= ram_wren_d;
      free_ptr    <= free_ptr_d;
    end
  end

  // Next-state and next-output logic; ram_wren defaults low so it can only
  // be high for the single ISSUE cycle.
  always_comb begin
    state_d       = state;
    op_d          = op;
    req_ready_d   = req_ready;
    resp_valid_d  = resp_valid;
    resp_data_d   = resp_data;
    resp_addr_d   = resp_addr;
    resp_err_d    = resp_err;
    ram_address_d = ram_address;
    ram_data_d    = ram_data;
    ram_wren_d    = 1'b0;
    free_ptr_d    = free_ptr;

    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          op_d        = op_t'(req_op);
          req_ready_d = 1'b0;
          if ((op_t'(req_op) == OP_RSVD) ||
              ((op_t'(req_op) == OP_ALLOC) && mem_full)) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = '0;
            resp_addr_d  = '0;
          end else begin
            state_d       = ST_ISSUE;
            ram_data_d    = req_data;
            ram_address_d = (op_t'(req_op) == OP_ALLOC) ? free_ptr[ADDR_W-1:0] : req_addr;
            ram_wren_d    = (op_t'(req_op) != OP_READ);
          end
        end
      end

      ST_ISSUE: begin
        if (op == OP_READ) begin
          state_d = ST_WAIT;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_data_d  = '0;
          resp_addr_d  = ram_address;
          if ((op == OP_ALLOC) && !mem_full) begin
            free_ptr_d = free_ptr + PTR_ONE;
          end
        end
      end

      ST_WAIT: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_data_d  = ram_q;
        resp_addr_d  = ram_address;
      end

      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural 1-cycle registered RAM.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int unsigned AW = MC_ADDR_W;
  localparam int unsigned DW = MC_DATA_W;

  logic          clock;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic [AW-1:0] resp_addr;
  logic          resp_err;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q;
  logic [AW:0]   free_ptr;
  logic          mem_full;

  int errors = 0;
  int checks = 0;

  mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ALLOC_BASE(0)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_addr   (resp_addr),
    .resp_err    (resp_err),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q),
    .free_ptr    (free_ptr),
    .mem_full    (mem_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port RAM with registered read.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (ram_wren) ram[ram_address] <= ram_data;
    ram_q <= ram[ram_address];
  end

  // Write-strobe bookkeeping: total pulses and back-to-back pulses.
  int   wren_cnt = 0;
  int   b2b_cnt  = 0;
  logic wren_prev = 1'b0;
  always @(posedge clock) begin
    if (ram_wren) wren_cnt <= wren_cnt + 1;
    if (ram_wren && wren_prev) b2b_cnt <= b2b_cnt + 1;
    wren_prev <= ram_wren;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents a request and returns 1 time unit after its accept edge.
  task automatic send(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int n;
    @(negedge clock);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("accept_ready", 64'(req_ready), 1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  // Edges from accept to the edge where resp_valid is first seen; 0 on timeout.
  task automatic wait_resp(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (resp_valid) begin
        lat = k;
        break;
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_req(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        output int lat, output logic [DW-1:0] d, output logic [AW-1:0] a,
                        output logic e);
    send(op, addr, data);
    wait_resp(lat);
    d = resp_data;
    a = resp_addr;
    e = resp_err;
    if (lat != 0) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    int            lat;
    int            w0;
    int            bad;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic          e;

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_addr   = '0;
    req_data   = '0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;

    check("rst_req_ready",  64'(req_ready), 1);
    check("rst_resp_valid", 64'(resp_valid), 0);
    check("rst_resp_data",  resp_data, 0);
    check("rst_resp_addr",  64'(resp_addr), 0);
    check("rst_resp_err",   64'(resp_err), 0);
    check("rst_ram_wren",   64'(ram_wren), 0);
    check("rst_ram_addr",   64'(ram_address), 0);
    check("rst_ram_data",   ram_data, 0);
    check("rst_free_ptr",   64'(free_ptr), 0);
    check("rst_mem_full",   64'(mem_full), 0);

    // Write then read back one cell.
    w0 = wren_cnt;
    do_req(2'b01, 10'h005, 64'hDEADBEEF_CAFEF00D, lat, d, a, e);
    check("wr_lat",  64'(lat), 2);
    check("wr_err",  64'(e), 0);
    check("wr_addr", 64'(a), 5);
    check("wr_data", d, 0);
    check("wr_ready_after", 64'(req_ready), 1);
    do_req(2'b00, 10'h005, 64'h0, lat, d, a, e);
    check("rd_lat",  64'(lat), 3);
    check("rd_data", d, 64'hDEADBEEF_CAFEF00D);
    check("rd_err",  64'(e), 0);
    check("rd_addr", 64'(a), 5);
    check("wr_rd_pulses", 64'(wren_cnt - w0), 1);

    // Three allocations from reset.
    for (int i = 0; i < 3; i++) begin
      do_req(2'b10, 10'h3FF, 64'(i + 1), lat, d, a, e);
      check("alloc_lat",  64'(lat), 2);
      check("alloc_addr", 64'(a), 64'(i));
      check("alloc_err",  64'(e), 0);
    end
    check("alloc_free_ptr", 64'(free_ptr), 3);
    for (int i = 0; i < 3; i++) begin
      do_req(2'b00, AW'(i), 64'h0, lat, d, a, e);
      check("alloc_rd_data", d, 64'(i + 1));
    end

    // Reserved op: immediate error, no RAM traffic.
    w0 = wren_cnt;
    do_req(2'b11, 10'h123, 64'h55, lat, d, a, e);
    check("rsvd_lat",      64'(lat), 1);
    check("rsvd_err",      64'(e), 1);
    check("rsvd_data",     d, 0);
    check("rsvd_no_wren",  64'(wren_cnt - w0), 0);
    check("rsvd_ram_addr", 64'(ram_address), 2);
    check("rsvd_free_ptr", 64'(free_ptr), 3);

    // Response back-pressure on a read.
    resp_ready = 1'b0;
    send(2'b00, 10'h005, 64'h0);
    wait_resp(lat);
    check("hold_lat", 64'(lat), 3);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 64'(resp_valid), 1);
      check("hold_data",  resp_data, 64'hDEADBEEF_CAFEF00D);
      check("hold_ready", 64'(req_ready), 0);
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    check("hold_release_ready", 64'(req_ready), 1);
    check("hold_release_valid", 64'(resp_valid), 0);

    // Reset during the ISSUE cycle of a write aborts it.
    do_req(2'b01, 10'h010, 64'h5555, lat, d, a, e);
    w0 = wren_cnt;
    send(2'b01, 10'h010, 64'hAA);
    check("abort_wren_issue", 64'(ram_wren), 1);
    reset = 1'b1;
    #1;
    check("abort_wren_drop",   64'(ram_wren), 0);
    check("abort_req_ready",   64'(req_ready), 1);
    check("abort_resp_valid",  64'(resp_valid), 0);
    check("abort_ram_addr",    64'(ram_address), 0);
    check("abort_free_ptr",    64'(free_ptr), 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("abort_no_write", 64'(wren_cnt - w0), 0);
    do_req(2'b00, 10'h010, 64'h0, lat, d, a, e);
    check("abort_rd_data", d, 64'h5555);

    // Fill the whole RAM by allocation, then hit exhaustion.
    bad = 0;
    for (int i = 0; i < 1023; i++) begin
      do_req(2'b10, 10'h0, 64'(i), lat, d, a, e);
      if ((a != AW'(i)) || e || (lat != 2)) bad++;
    end
    check("fill_bad_count", 64'(bad), 0);
    check("fill_free_ptr",  64'(free_ptr), 1023);
    check("fill_not_full",  64'(mem_full), 0);
    do_req(2'b10, 10'h0, 64'h77, lat, d, a, e);
    check("last_alloc_addr", 64'(a), 1023);
    check("last_alloc_err",  64'(e), 0);
    check("last_mem_full",   64'(mem_full), 1);
    check("last_free_ptr",   64'(free_ptr), 1024);
    w0 = wren_cnt;
    do_req(2'b10, 10'h0, 64'h99, lat, d, a, e);
    check("full_alloc_lat",  64'(lat), 1);
    check("full_alloc_err",  64'(e), 1);
    check("full_no_wren",    64'(wren_cnt - w0), 0);
    check("full_free_ptr",   64'(free_ptr), 1024);
    do_req(2'b00, 10'h3FF, 64'h0, lat, d, a, e);
    check("full_rd_top", d, 64'h77);
    do_req(2'b00, 10'd500, 64'h0, lat, d, a, e);
    check("full_rd_mid", d, 64'd500);

    check("wren_back_to_back", 64'(b2b_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
